// File: rtl/axi_imem_loader_pkg.sv
// Shared constants, state encoding and burst sizing helper for the AXI image loader.
// Burst sizing keeps every INCR burst inside one 4 KB page.
package axi_loader_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_8B    = 3'd3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_FILL = 3'd1;
    localparam state_t ST_ADDR = 3'd2;
    localparam state_t ST_DATA = 3'd3;
    localparam state_t ST_RESP = 3'd4;

    // Beats for the next burst: the smallest of the burst cap, the room left
    // in the current 4 KB page and the words available.
    function automatic logic [9:0] burst_len(
        input logic [11:0] addr_lo,
        input logic [9:0]  avail,
        input logic [9:0]  max_beats
    );
        logic [9:0] to_4k;
        logic [9:0] len;
        to_4k = 10'd512 - {1'b0, addr_lo[11:3]};
        len   = max_beats;
        if (to_4k < len) begin
            len = to_4k;
        end
        if (avail < len) begin
            len = avail;
        end
        return len;
    endfunction

endpackage

// File: rtl/axi_imem_loader_fifo.sv
// Synchronous show-ahead FIFO holding {tlast, tdata} words between the
// stream input and the AXI W channel; exposes its fill level.
module loader_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 65
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr_reg];
    assign full     = (count_reg == CNT_W'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;

endmodule

// File: rtl/axi_imem_loader.sv
// AXI4 write-burst master: packs a 64-bit word stream into 4 KB-safe INCR
// bursts starting at a commanded base address, one burst in flight at a time.
module axi_imem_loader
    import axi_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 8,
    parameter int AXI_ID     = 0,
    parameter int MAX_BURST  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    output logic [ID_WIDTH-1:0]       m_axi_awid,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [ID_WIDTH-1:0]       m_axi_bid,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [31:0]               beat_count
);

    localparam int CNT_W  = $clog2(MAX_BURST) + 1;
    localparam int FIFO_W = DATA_WIDTH + 1;

    state_t                 state_reg, state_next;
    logic [ADDR_WIDTH-1:0]  addr_reg, addr_next;
    logic [8:0]             len_reg, len_next;
    logic [8:0]             beat_idx_reg, beat_idx_next;
    logic                   last_seen_reg, last_seen_next;
    logic                   burst_last_reg, burst_last_next;
    logic                   error_reg, error_next;
    logic                   done_reg, done_next;
    logic [31:0]            beat_count_reg, beat_count_next;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic [FIFO_W-1:0]      fifo_rd_data;

    logic [9:0]             fifo_avail;
    logic [9:0]             burst_cap;
    logic [9:0]             burst_fit;
    logic                   fill_go;
    logic                   unused_bits;

    loader_fifo #(
        .DEPTH (MAX_BURST),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({s_axis_tlast, s_axis_tdata}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // The stream is closed once the tlast word is in, so the FIFO never holds
    // words of a following image and tlast is always its newest entry.
    assign cmd_ready     = (state_reg == ST_IDLE);
    assign s_axis_tready = (state_reg != ST_IDLE) && !fifo_full && !last_seen_reg;
    assign fifo_push     = s_axis_tvalid && s_axis_tready;

    assign fifo_avail = 10'(fifo_count);
    assign burst_cap  = burst_len(addr_reg[11:0], 10'(MAX_BURST), 10'(MAX_BURST));
    assign burst_fit  = burst_len(addr_reg[11:0], fifo_avail, 10'(MAX_BURST));
    assign fill_go    = (fifo_avail >= burst_cap) || last_seen_reg;

    assign m_axi_awid    = ID_WIDTH'(AXI_ID);
    assign m_axi_awaddr  = addr_reg;
    assign m_axi_awlen   = 8'(len_reg - 9'd1);
    assign m_axi_awsize  = AXI_SIZE_8B;
    assign m_axi_awburst = AXI_BURST_INCR;
    assign m_axi_awvalid = (state_reg == ST_ADDR);

    assign m_axi_wdata  = fifo_rd_data[DATA_WIDTH-1:0];
    assign m_axi_wstrb  = '1;
    assign m_axi_wvalid = (state_reg == ST_DATA) && !fifo_empty;
    assign m_axi_wlast  = (beat_idx_reg == len_reg - 9'd1);
    assign fifo_pop     = m_axi_wvalid && m_axi_wready;

    assign m_axi_bready = (state_reg == ST_RESP);

    assign busy       = (state_reg != ST_IDLE);
    assign done       = done_reg;
    assign error      = error_reg;
    assign beat_count = beat_count_reg;

    assign unused_bits = ^{m_axi_bid, cmd_addr[2:0]};

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        len_next        = len_reg;
        beat_idx_next   = beat_idx_reg;
        last_seen_next  = last_seen_reg;
        burst_last_next = burst_last_reg;
        error_next      = error_reg;
        done_next       = 1'b0;
        beat_count_next = beat_count_reg;

        if (fifo_push && s_axis_tlast) begin
            last_seen_next = 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_next       = {cmd_addr[ADDR_WIDTH-1:3], 3'b000};
                    error_next      = 1'b0;
                    beat_count_next = '0;
                    last_seen_next  = 1'b0;
                    state_next      = ST_FILL;
                end
            end
            ST_FILL: begin
                if (fill_go) begin
                    len_next        = burst_fit[8:0];
                    beat_idx_next   = '0;
                    burst_last_next = 1'b0;
                    state_next      = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (m_axi_awready) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (fifo_pop) begin
                    if (fifo_rd_data[DATA_WIDTH]) begin
                        burst_last_next = 1'b1;
                    end
                    if (m_axi_wlast) begin
                        state_next = ST_RESP;
                    end else begin
                        beat_idx_next = beat_idx_reg + 9'd1;
                    end
                end
            end
            ST_RESP: begin
                if (m_axi_bvalid) begin
                    beat_count_next = beat_count_reg + 32'(len_reg);
                    addr_next       = addr_reg + (ADDR_WIDTH'(len_reg) << 3);
                    if (m_axi_bresp != AXI_RESP_OKAY) begin
                        error_next = 1'b1;
                    end
                    // A failed burst is reported but the image carries on.
                    if (burst_last_reg) begin
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_FILL;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            len_reg        <= 9'd1;
            beat_idx_reg   <= '0;
            last_seen_reg  <= 1'b0;
            burst_last_reg <= 1'b0;
            error_reg      <= 1'b0;
            done_reg       <= 1'b0;
            beat_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            len_reg        <= len_next;
            beat_idx_reg   <= beat_idx_next;
            last_seen_reg  <= last_seen_next;
            burst_last_reg <= burst_last_next;
            error_reg      <= error_next;
            done_reg       <= done_next;
            beat_count_reg <= beat_count_next;
        end
    end

endmodule

// File: tb/tb_axi_imem_loader.sv
// Randomized bench for axi_imem_loader: a page-splitting burst model fills
// scoreboard queues, and a slave/monitor process checks every AXI handshake.
module tb_axi_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [63:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [7:0]  m_axi_awid;
    logic [15:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [63:0] m_axi_wdata;
    logic [7:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic [7:0]  m_axi_bid = '0;
    logic [1:0]  m_axi_bresp = '0;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] beat_count;

    always #5 clk = ~clk;

    axi_imem_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_addr      (cmd_addr),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axi_awid    (m_axi_awid),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awlen   (m_axi_awlen),
        .m_axi_awsize  (m_axi_awsize),
        .m_axi_awburst (m_axi_awburst),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wlast   (m_axi_wlast),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bid     (m_axi_bid),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .beat_count    (beat_count)
    );

    typedef struct { logic [15:0] addr; int len; } burst_t;
    typedef struct { logic [63:0] data; logic last; } beat_t;

    burst_t      exp_aw_q[$];
    beat_t       exp_w_q[$];
    beat_t       stream_q[$];
    logic [63:0] img_words[$];
    logic [63:0] ram [0:8191];

    int errors = 0;
    int checks = 0;
    int stall_pct = 0;
    int gap_pct = 0;
    int err_target = -1;
    int aw_total = 0;
    int wb_total = 0;
    int w_beat_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: walk the image, cutting bursts at 16 beats, at each
    // 4 KB page end and at the end of the image.
    task automatic build_expect(input logic [15:0] base, input int n);
        int remaining;
        int idx;
        int to_4k;
        int len;
        int a;
        burst_t b;
        beat_t w;
        a = int'(base);
        remaining = n;
        idx = 0;
        while (remaining > 0) begin
            to_4k = (4096 - (a % 4096)) / 8;
            len = 16;
            if (to_4k < len) len = to_4k;
            if (remaining < len) len = remaining;
            b.addr = 16'(a);
            b.len = len;
            exp_aw_q.push_back(b);
            for (int k = 0; k < len; k++) begin
                w.data = img_words[idx + k];
                w.last = (k == len - 1);
                exp_w_q.push_back(w);
            end
            idx += len;
            remaining -= len;
            a = (a + len * 8) % 65536;
        end
    endtask

    // Stream source: holds a presented word until the loader takes it.
    initial begin : stream_driver
        bit hold;
        hold = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                s_axis_tvalid = 1'b0;
                hold = 0;
            end else begin
                if (!hold) begin
                    if (stream_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
                        s_axis_tvalid = 1'b1;
                        s_axis_tdata  = stream_q[0].data;
                        s_axis_tlast  = stream_q[0].last;
                    end else begin
                        s_axis_tvalid = 1'b0;
                    end
                end
                hold = 0;
                if (s_axis_tvalid) begin
                    if (s_axis_tready) void'(stream_q.pop_front());
                    else hold = 1;
                end
            end
        end
    end

    // Slave memory plus monitor: decides handshakes for the coming edge and
    // checks them against the scoreboard queues.
    initial begin : slave_monitor
        burst_t      slv_aw_q[$];
        logic [1:0]  b_q[$];
        logic [15:0] w_addr;
        bit          w_first;
        bit          b_hold;
        bit          aw_pend;
        bit          w_pend;
        logic [15:0] pend_awaddr;
        logic [7:0]  pend_awlen;
        logic [63:0] pend_wdata;
        logic        pend_wlast;
        burst_t      ab;
        beat_t       wb;
        w_first = 1; b_hold = 0; aw_pend = 0; w_pend = 0; w_addr = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                slv_aw_q.delete();
                b_q.delete();
                w_first = 1; b_hold = 0; aw_pend = 0; w_pend = 0;
                aw_total = wb_total;
                m_axi_awready = 1'b0;
                m_axi_wready  = 1'b0;
                m_axi_bvalid  = 1'b0;
            end else begin
                if (!b_hold) begin
                    if (b_q.size() > 0 && $urandom_range(0, 99) >= stall_pct) begin
                        m_axi_bvalid = 1'b1;
                        m_axi_bresp  = b_q[0];
                    end else begin
                        m_axi_bvalid = 1'b0;
                    end
                end
                b_hold = 0;
                if (m_axi_bvalid) begin
                    if (m_axi_bready) void'(b_q.pop_front());
                    else b_hold = 1;
                end

                m_axi_wready = ($urandom_range(0, 99) >= stall_pct);
                if (w_pend) begin
                    check("w_stable_valid", m_axi_wvalid, 1'b1);
                    check("w_stable_data", m_axi_wdata, pend_wdata);
                    check("w_stable_last", m_axi_wlast, pend_wlast);
                end
                w_pend = 0;
                if (m_axi_wvalid) begin
                    if (m_axi_wready) begin
                        check("w_after_aw", (aw_total > wb_total), 1'b1);
                        check("w_strb", m_axi_wstrb, 8'hFF);
                        if (exp_w_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL w_unexpected: got beat %0h expected none", m_axi_wdata);
                        end else begin
                            wb = exp_w_q.pop_front();
                            check("w_data", m_axi_wdata, wb.data);
                            check("w_last", m_axi_wlast, wb.last);
                        end
                        if (w_first && slv_aw_q.size() > 0) w_addr = slv_aw_q[0].addr;
                        w_first = 0;
                        ram[w_addr[15:3]] = m_axi_wdata;
                        w_addr = w_addr + 16'd8;
                        w_beat_total++;
                        if (m_axi_wlast) begin
                            if (slv_aw_q.size() > 0) void'(slv_aw_q.pop_front());
                            w_first = 1;
                            wb_total++;
                            b_q.push_back((wb_total == err_target) ? 2'b10 : 2'b00);
                        end
                    end else begin
                        w_pend = 1;
                        pend_wdata = m_axi_wdata;
                        pend_wlast = m_axi_wlast;
                    end
                end

                m_axi_awready = ($urandom_range(0, 99) >= stall_pct);
                if (aw_pend) begin
                    check("aw_stable_valid", m_axi_awvalid, 1'b1);
                    check("aw_stable_addr", m_axi_awaddr, pend_awaddr);
                    check("aw_stable_len", m_axi_awlen, pend_awlen);
                end
                aw_pend = 0;
                if (m_axi_awvalid) begin
                    if (m_axi_awready) begin
                        if (exp_aw_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL aw_unexpected: got addr %0h expected none", m_axi_awaddr);
                        end else begin
                            ab = exp_aw_q.pop_front();
                            check("aw_addr", m_axi_awaddr, ab.addr);
                            check("aw_len", m_axi_awlen, 8'(ab.len - 1));
                        end
                        check("aw_size", m_axi_awsize, 3'd3);
                        check("aw_burst", m_axi_awburst, 2'b01);
                        check("aw_id", m_axi_awid, 8'd0);
                        ab.addr = m_axi_awaddr;
                        ab.len = int'(m_axi_awlen) + 1;
                        slv_aw_q.push_back(ab);
                        aw_total++;
                    end else begin
                        aw_pend = 1;
                        pend_awaddr = m_axi_awaddr;
                        pend_awlen = m_axi_awlen;
                    end
                end
            end
        end
    end

    task automatic load_stream(input logic [15:0] cmd, input int n);
        beat_t w;
        img_words.delete();
        for (int i = 0; i < n; i++) begin
            img_words.push_back({$urandom(), $urandom()});
            w.data = img_words[i];
            w.last = (i == n - 1);
            stream_q.push_back(w);
        end
        build_expect(cmd & 16'hFFF8, n);
    endtask

    task automatic issue_cmd(input logic [15:0] cmd);
        @(negedge clk);
        cmd_addr = cmd;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("cmd_busy", busy, 1'b1);
        check("cmd_ready_low", cmd_ready, 1'b0);
        check("cmd_err_clr", error, 1'b0);
        check("cmd_bc_clr", beat_count, 32'd0);
    endtask

    task automatic run_image(input logic [15:0] cmd, input int n, input bit inject, input bit exp_err);
        int cyc;
        int mism;
        logic [15:0] a;
        load_stream(cmd, n);
        err_target = inject ? wb_total + 2 : -1;
        repeat (3) @(negedge clk);
        check("idle_tready", s_axis_tready, 1'b0);
        check("idle_cmd_ready", cmd_ready, 1'b1);
        issue_cmd(cmd);
        cyc = 0;
        while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", cyc);
            return;
        end
        check("beat_count", beat_count, 32'(n));
        check("error_at_done", error, exp_err);
        check("aw_left", exp_aw_q.size(), 0);
        check("w_left", exp_w_q.size(), 0);
        mism = 0;
        a = cmd & 16'hFFF8;
        for (int i = 0; i < n; i++) begin
            if (ram[a[15:3]] !== img_words[i]) mism++;
            a = a + 16'd8;
        end
        check("ram_words", mism, 0);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("error_sticky", error, exp_err);
        $display("image at %h: %0d words, beat_count=%0d error=%0b", cmd, n, beat_count, error);
    endtask

    task automatic reset_mid_data();
        int cyc;
        int start;
        load_stream(16'h3000, 40);
        err_target = -1;
        start = w_beat_total;
        issue_cmd(16'h3000);
        cyc = 0;
        while (!(w_beat_total >= start + 20 && m_axi_wvalid) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("pre_reset_wvalid", m_axi_wvalid, 1'b1);
        check("pre_reset_bc", beat_count, 32'd16);
        #2 rst_n = 1'b0;
        #1;
        check("rst_awvalid", m_axi_awvalid, 1'b0);
        check("rst_wvalid", m_axi_wvalid, 1'b0);
        check("rst_bready", m_axi_bready, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_beat_count", beat_count, 32'd0);
        check("rst_awaddr", m_axi_awaddr, 16'd0);
        stream_q.delete();
        exp_aw_q.delete();
        exp_w_q.delete();
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b1;
        $display("reset asserted mid-burst, beat_count=%0d", beat_count);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) ram[i] = '0;
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_awvalid", m_axi_awvalid, 1'b0);
        check("reset_wvalid", m_axi_wvalid, 1'b0);
        check("reset_bready", m_axi_bready, 1'b0);
        check("reset_tready", s_axis_tready, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_error", error, 1'b0);
        check("reset_beat_count", beat_count, 32'd0);
        check("reset_awaddr", m_axi_awaddr, 16'd0);
        #3 rst_n = 1'b1;

        run_image(16'h0000, 40, 0, 0);
        run_image(16'h0FF0, 5, 0, 0);
        run_image(16'h0008, 1, 0, 0);
        run_image(16'hFFF0, 4, 0, 0);
        run_image(16'h0105, 3, 0, 0);

        run_image(16'h2000, 40, 1, 1);
        repeat (5) @(negedge clk);
        check("error_held", error, 1'b1);
        run_image(16'h2400, 8, 0, 0);

        stall_pct = 30;
        gap_pct = 30;
        run_image(16'($urandom_range(0, 65535)), 100, 0, 0);
        run_image(16'($urandom_range(0, 65535)), 100, 0, 0);
        stall_pct = 0;
        gap_pct = 0;

        reset_mid_data();
        run_image(16'h3000, 20, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_imem_loader.md
Name: axi_imem_loader

Overview:
- AXI4 write-burst master that loads program or data images into a core's AXI slave memory port (imem/dmem), sitting directly upstream of the core wrapper's s_axi write channels.
- Accepts a load command (base address) plus a 64-bit AXI-Stream of words and packs the words into INCR bursts that never cross a 4 KB boundary.
- Reports completion and errors to the host/scheduler.

Parameters:
- DATA_WIDTH, 64, AXI/stream data width; fixed at 64 (awsize=3).
- ADDR_WIDTH, 16, AXI address width.
- ID_WIDTH, 8, AXI ID width.
- AXI_ID, 0, constant awid driven on every burst.
- MAX_BURST, 16, maximum beats per burst; power of 2, 2..256; also the internal FIFO depth.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_addr  in  ADDR_WIDTH  load base address; bits [2:0] ignored (forced 0)
- cmd_valid  in  1  command valid
- cmd_ready  out  1  high only in IDLE
- s_axis_tdata  in  DATA_WIDTH  image word
- s_axis_tvalid  in  1  word valid
- s_axis_tready  out  1  FIFO not full and a command is active
- s_axis_tlast  in  1  last word of image
- m_axi_awid  out  ID_WIDTH  = AXI_ID
- m_axi_awaddr  out  ADDR_WIDTH  burst address
- m_axi_awlen  out  8  beats-1
- m_axi_awsize  out  3  constant 3
- m_axi_awburst  out  2  constant 2'b01 (INCR)
- m_axi_awvalid  out  1  address valid
- m_axi_awready  in  1  address ready
- m_axi_wdata  out  DATA_WIDTH  write data
- m_axi_wstrb  out  DATA_WIDTH/8  all ones
- m_axi_wlast  out  1  last beat of burst
- m_axi_wvalid  out  1  data valid
- m_axi_wready  in  1  data ready
- m_axi_bid  in  ID_WIDTH  ignored
- m_axi_bresp  in  2  write response
- m_axi_bvalid  in  1  response valid
- m_axi_bready  out  1  high only in RESP
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when the image completes
- error  out  1  sticky; set on any bresp != 2'b00; cleared on the next accepted command
- beat_count  out  32  beats acknowledged for the current/last image

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, FIFO empty, all valid/ready outputs 0 except cmd_ready=1, done=0, error=0, beat_count=0, m_axi_awaddr=0. Reset mid-burst aborts with no further AXI activity; the slave is assumed to be reset too.
- Sync FIFO, depth MAX_BURST, 65-bit entries {tlast, tdata}. Push on tvalid&&tready. Stream words arriving while IDLE are not accepted.
- States:
  - IDLE: cmd_valid&&cmd_ready latches addr (aligned to 8 bytes), clears error and beat_count, goes to FILL.
  - FILL: computes len = min(MAX_BURST, beats_to_4k, fifo_count), where beats_to_4k = (4096 - addr[11:0])/8. Goes to ADDR when fifo_count >= min(MAX_BURST, beats_to_4k), or when a tlast word is in the FIFO (burst ends at the tlast word).
  - ADDR: awvalid=1 with awlen=len-1 held stable until awready. Then DATA.
  - DATA: pops the FIFO onto W, wvalid = FIFO non-empty. wlast asserted on beat len. After the wlast handshake go to RESP. W is never issued before its AW handshake.
  - RESP: bready=1. On bvalid: beat_count += len; addr += len*8 (mod 2^ADDR_WIDTH); error |= (bresp != 0). If the burst contained tlast, pulse done and go to IDLE; else go to FILL.
- Only one burst outstanding. The stream keeps filling the FIFO during ADDR/DATA/RESP.
- Address wrap at 2^ADDR_WIDTH is silent; 4 KB split takes priority over MAX_BURST.
- A zero-beat image is impossible; the tlast word is always written.
- The error path continues the image; error does not abort.

Decomposition:
- Shared package (axi_loader_pkg): AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00, state enum {IDLE, FILL, ADDR, DATA, RESP}, a burst length calc function.
- One natural sub-module: loader_fifo (sync FIFO with count output, depth MAX_BURST).

Test Plan:
- cmd_addr=0x0000, 40 words (last has tlast), slave always ready -> bursts at 0x0000 len16, 0x0080 len16, 0x0100 len8; done pulse once; beat_count=40; RAM matches data.
- cmd_addr=0x0FF0, 5 words -> burst 0x0FF0 awlen=1, then 0x1000 awlen=2; no burst crosses 0x1000.
- Random stall on awready/wready/bvalid and gaps in tvalid, 100 words -> AW/W stable while stalled, wlast only on final beat of each burst, data in order.
- Slave returns bresp=2'b10 on the second burst of 3 -> error=1 and stays set, done still pulses, next command clears error.
- rst_n deasserted-then-asserted mid-DATA -> all valids drop asynchronously, cmd_ready=1, beat_count=0; new command loads correctly.
- Single word with tlast at 0x0008 -> one burst awlen=0, wlast=1 on the first beat, done pulse, beat_count=1.
